// File: rtl/aes256_pkg.sv
// Shared types and constants for the AES-256 unloading stage.
// State encoding, block geometry and error flag positions.
package aes256_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_W      = 8;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERRUN = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/aes256_if.sv
// Bundle for the encryption core, the unloading stage and its consumer.
// The modports give each side's view of the byte and block handshakes.
interface aes256_if
  import aes256_pkg::*;
#(
  parameter int NUM_BYTES = AES_BLOCK_BYTES,
  parameter int BYTE_W    = AES_BYTE_W
) (
  input logic clk
);

  logic                        rst_n;
  logic                        enc_done;
  logic                        next_val_req;
  logic                        next_val_ready;
  logic [BYTE_W-1:0]           data;
  logic                        valid;
  logic                        ready;
  logic [NUM_BYTES*BYTE_W-1:0] block_out;
  logic                        busy;
  logic [1:0]                  err;
  logic                        clr_err;

  modport unloader (
    input  clk, rst_n, enc_done, next_val_ready,
    input  data, ready, clr_err,
    output next_val_req, valid, block_out, busy, err
  );

  modport upstream (
    input  clk, rst_n, next_val_req, busy,
    output enc_done, next_val_ready, data
  );

  modport consumer (
    input  clk, rst_n, valid, block_out, err, busy,
    output ready, clr_err
  );

endinterface

// File: rtl/aes256_byte_packer.sv
// Shift register that assembles upstream bytes MSB-first into a block,
// plus the byte counter that flags the final byte of the block.
module aes256_byte_packer
  import aes256_pkg::*;
#(
  parameter int NUM_BYTES = AES_BLOCK_BYTES,
  parameter int BYTE_W    = AES_BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        shift_en,
  input  logic [BYTE_W-1:0]           byte_in,
  output logic                        last,
  output logic [NUM_BYTES*BYTE_W-1:0] word_out
);

  localparam int W  = NUM_BYTES * BYTE_W;
  localparam int CW = $clog2(NUM_BYTES);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (shift_en) begin
      r_sr <= {r_sr[W-BYTE_W-1:0], byte_in};
      if (!last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign last     = (r_cnt == CW'(NUM_BYTES - 1));
  assign word_out = r_sr;

endmodule

// File: rtl/aes256_unloading.sv
// Pulls the ciphertext out of the AES core byte by byte and hands the
// reassembled block to the consumer; flags stalls and early restarts.
module aes256_unloading
  import aes256_pkg::*;
#(
  parameter int NUM_BYTES   = AES_BLOCK_BYTES,
  parameter int BYTE_W      = AES_BYTE_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pi_enc_done,
  output logic                        po_next_val_req,
  input  logic                        pi_next_val_ready,
  input  logic [BYTE_W-1:0]           pi_data,
  output logic                        po_valid,
  input  logic                        pi_ready,
  output logic [NUM_BYTES*BYTE_W-1:0] po_data,
  output logic                        po_busy,
  output logic [1:0]                  po_err,
  input  logic                        pi_clr_err
);

  localparam int W  = NUM_BYTES * BYTE_W;
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  state_t          r_state;
  logic [TW-1:0]   r_tcnt;
  logic            r_req;
  logic            r_valid;
  logic [W-1:0]    r_data;
  logic [1:0]      r_err;

  logic            w_start;
  logic            w_shift;
  logic            w_last;
  logic            w_tout;
  logic            w_ovr;
  logic [1:0]      w_set;
  logic [W-1:0]    w_word;
  logic [W-1:0]    w_next;

  aes256_byte_packer #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_start),
    .shift_en (w_shift),
    .byte_in  (pi_data),
    .last     (w_last),
    .word_out (w_word)
  );

  // A start is legal from IDLE or on the very cycle OUT is accepted.
  assign w_start = pi_enc_done &&
                   ((r_state == IDLE) ||
                    ((r_state == OUT) && pi_ready));
  assign w_shift = (r_state == WAIT) && pi_next_val_ready;
  assign w_next  = {w_word[W-BYTE_W-1:0], pi_data};

  assign w_tout = (TIMEOUT_CYC != 0) &&
                  (r_state == WAIT) &&
                  !pi_next_val_ready &&
                  (r_tcnt == TW'(TIMEOUT_CYC - 1));
  assign w_ovr  = pi_enc_done &&
                  ((r_state == REQ) ||
                   (r_state == WAIT) ||
                   ((r_state == OUT) && !pi_ready));

  always_comb begin
    w_set              = '0;
    w_set[ERR_TIMEOUT] = w_tout;
    w_set[ERR_OVERRUN] = w_ovr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= '0;
    end else begin
      r_req <= 1'b0;
      r_err <= (pi_clr_err ? 2'b00 : r_err) | w_set;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          r_tcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (pi_next_val_ready) begin
            if (w_last) begin
              r_state <= OUT;
              r_valid <= 1'b1;
              r_data  <= w_next;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end else if (w_tout) begin
            r_state <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        OUT: begin
          if (pi_ready) begin
            r_valid <= 1'b0;
            if (w_start) begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign po_next_val_req = r_req;
  assign po_valid        = r_valid;
  assign po_data         = r_data;
  assign po_err          = r_err;
  assign po_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_aes256_unloading.sv
// Bench for aes256_unloading: an upstream byte source with random answer
// delays, checked against a block model built directly from the byte list.
module tb_aes256_unloading;

  localparam int NB = 16;
  localparam int BW = 8;
  localparam int W  = NB * BW;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enc_done = 1'b0;
  logic          nvr = 1'b0;
  logic [BW-1:0] din = '0;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;
  logic          req;
  logic          valid;
  logic          busy;
  logic [W-1:0]  dout;
  logic [1:0]    err;

  int vectors = 0;
  int miscompares = 0;
  int nreq = 0;

  logic [BW-1:0] blk [NB];
  logic [W-1:0]  last_exp = '0;

  always #5 clk = ~clk;

  always @(posedge clk) if (req === 1'b1) nreq <= nreq + 1;

  aes256_unloading #(
    .NUM_BYTES   (NB),
    .BYTE_W      (BW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pi_enc_done       (enc_done),
    .po_next_val_req   (req),
    .pi_next_val_ready (nvr),
    .pi_data           (din),
    .po_valid          (valid),
    .pi_ready          (rdy),
    .po_data           (dout),
    .po_busy           (busy),
    .po_err            (err),
    .pi_clr_err        (clr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Byte i of the list lands in slot i counted down from the MSB.
  function automatic logic [W-1:0] model();
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[W-1-BW*i -: BW] = blk[i];
    return m;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < NB; i++) blk[i] = 8'($urandom);
  endtask

  // Upstream side: answer n_ans requests, each 1+rand(0..maxd) cycles late.
  task automatic xfer(input bit start, input int n_ans, input int maxd,
                      input int ovr_at, input bit glitch, output int lat);
    int t;
    int d;
    lat = 0;
    if (start) begin
      enc_done = 1'b1;
      cyc();
      lat++;
      enc_done = 1'b0;
    end
    for (int i = 0; i < n_ans; i++) begin
      t = 0;
      while (req !== 1'b1 && t < 200) begin
        cyc();
        lat++;
        t++;
      end
      vectors++;
      if (req !== 1'b1) begin
        miscompares++;
        $display("FAIL req_wait byte %0d: req=%b, want 1 within 200 cycles",
                 i, req);
        return;
      end
      if (glitch) begin
        nvr = 1'b1;
        din = ~blk[i];
      end
      cyc();
      lat++;
      nvr = 1'b0;
      vectors++;
      if (req !== 1'b0) begin
        miscompares++;
        $display("FAIL req_pulse byte %0d: req=%b, want 0", i, req);
      end
      d = $urandom_range(maxd, 0);
      repeat (d) begin
        cyc();
        lat++;
      end
      if (i == ovr_at) enc_done = 1'b1;
      nvr = 1'b1;
      din = blk[i];
      cyc();
      lat++;
      nvr = 1'b0;
      enc_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    vectors++;
    if (req !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: req=%b valid=%b busy=%b, want 0 0 0",
               req, valid, busy);
    end
    vectors++;
    if (dout !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, want 0", dout);
    end
    vectors++;
    if (err !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_err: got %b, want 00", err);
    end
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (busy !== 1'b0 || req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b req=%b, want 0 0", busy, req);
    end
  endtask

  task automatic test_nominal();
    int lat;
    int n0;
    rdy = 1'b1;
    for (int i = 0; i < NB; i++) blk[i] = 8'(i);
    n0 = nreq;
    xfer(1'b1, NB, 0, -1, 1'b0, lat);
    vectors++;
    if (valid !== 1'b1 || lat != 33) begin
      miscompares++;
      $display("FAIL nom_latency: valid=%b after %0d cycles, want 1 after 33",
               valid, lat);
    end
    vectors++;
    if (dout !== 128'h000102030405060708090A0B0C0D0E0F) begin
      miscompares++;
      $display("FAIL nom_data: got %h, want 000102030405060708090a0b0c0d0e0f",
               dout);
    end
    vectors++;
    if (err !== 2'b00) begin
      miscompares++;
      $display("FAIL nom_err: got %b, want 00", err);
    end
    last_exp = model();
    cyc();
    vectors++;
    if (nreq - n0 != NB) begin
      miscompares++;
      $display("FAIL nom_reqs: got %0d req cycles, want %0d", nreq - n0, NB);
    end
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_idle: busy=%b valid=%b, want 0 0", busy, valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] exp;
    rdy = 1'b0;
    fill_rand();
    exp = model();
    xfer(1'b1, NB, 3, -1, 1'b0, lat);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (valid !== 1'b1 || dout !== exp) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d: valid=%b data=%h, want 1 %h",
                 k, valid, dout, exp);
      end
      cyc();
    end
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b busy=%b, want 0 0", valid, busy);
    end
    last_exp = exp;
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] exp;
    rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      fill_rand();
      exp = model();
      xfer(1'b1, NB, 4, -1, 1'b0, lat);
      vectors++;
      if (valid !== 1'b1 || dout !== exp || err !== 2'b00) begin
        miscompares++;
        $display("FAIL rand_blk %0d: valid=%b err=%b data=%h, want 1 00 %h",
                 n, valid, err, dout, exp);
      end
      last_exp = exp;
      cyc();
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit seen_valid;
    rdy = 1'b1;
    fill_rand();
    xfer(1'b1, 5, 2, -1, 1'b0, lat);
    vectors++;
    if (req !== 1'b1) begin
      miscompares++;
      $display("FAIL to_req6: req=%b, want 1", req);
    end
    seen_valid = 1'b0;
    // 64 stalled WAIT cycles follow the request; the flag shows after them.
    for (int k = 1; k <= 70; k++) begin
      cyc();
      if (valid === 1'b1) seen_valid = 1'b1;
      if (k == 64) begin
        vectors++;
        if (err !== 2'b00 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL to_early: err=%b busy=%b, want 00 1", err, busy);
        end
      end
      if (k == 65) begin
        vectors++;
        if (err !== 2'b01 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL to_flag: err=%b busy=%b, want 01 0", err, busy);
        end
      end
    end
    vectors++;
    if (seen_valid || dout !== last_exp) begin
      miscompares++;
      $display("FAIL to_data: valid_seen=%b data=%h, want 0 %h",
               seen_valid, dout, last_exp);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    vectors++;
    if (err !== 2'b00) begin
      miscompares++;
      $display("FAIL to_clr: err=%b, want 00", err);
    end
  endtask

  task automatic test_overrun();
    int lat;
    logic [W-1:0] exp;
    rdy = 1'b1;
    fill_rand();
    exp = model();
    xfer(1'b1, NB, 2, 3, 1'b0, lat);
    vectors++;
    if (valid !== 1'b1 || dout !== exp) begin
      miscompares++;
      $display("FAIL ovr_data: valid=%b data=%h, want 1 %h", valid, dout, exp);
    end
    vectors++;
    if (err !== 2'b10) begin
      miscompares++;
      $display("FAIL ovr_flag: err=%b, want 10", err);
    end
    last_exp = exp;
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    vectors++;
    if (err !== 2'b00) begin
      miscompares++;
      $display("FAIL ovr_clr: err=%b, want 00", err);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    rdy = 1'b0;
    fill_rand();
    exp_a = model();
    xfer(1'b1, NB, 1, -1, 1'b0, lat);
    vectors++;
    if (valid !== 1'b1 || dout !== exp_a) begin
      miscompares++;
      $display("FAIL b2b_first: valid=%b data=%h, want 1 %h",
               valid, dout, exp_a);
    end
    rdy = 1'b1;
    enc_done = 1'b1;
    cyc();
    rdy = 1'b0;
    enc_done = 1'b0;
    vectors++;
    if (req !== 1'b1 || busy !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart: req=%b busy=%b valid=%b, want 1 1 0",
               req, busy, valid);
    end
    vectors++;
    if (err !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_err: err=%b, want 00", err);
    end
    fill_rand();
    exp_b = model();
    xfer(1'b0, NB, 1, -1, 1'b0, lat);
    vectors++;
    if (valid !== 1'b1 || dout !== exp_b || err !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_second: valid=%b err=%b data=%h, want 1 00 %h",
               valid, err, dout, exp_b);
    end
    rdy = 1'b1;
    cyc();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b, want 0", busy);
    end
    last_exp = exp_b;
  endtask

  task automatic test_ignored();
    int lat;
    logic [W-1:0] exp;
    rdy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      nvr = 1'b1;
      din = 8'($urandom);
      cyc();
      nvr = 1'b0;
      cyc();
      vectors++;
      if (busy !== 1'b0 || req !== 1'b0) begin
        miscompares++;
        $display("FAIL ign_idle %0d: busy=%b req=%b, want 0 0", n, busy, req);
      end
    end
    fill_rand();
    exp = model();
    xfer(1'b1, NB, 0, -1, 1'b1, lat);
    vectors++;
    if (valid !== 1'b1 || lat != 33 || dout !== exp) begin
      miscompares++;
      $display("FAIL ign_block: valid=%b lat=%0d data=%h, want 1 33 %h",
               valid, lat, dout, exp);
    end
    last_exp = exp;
    cyc();
  endtask

  task automatic test_reset_mid();
    int lat;
    rdy = 1'b1;
    fill_rand();
    xfer(1'b1, 7, 1, 2, 1'b0, lat);
    cyc();
    vectors++;
    if (err !== 2'b10 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: err=%b busy=%b, want 10 1", err, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (req !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 ||
        err !== 2'b00 || dout !== '0) begin
      miscompares++;
      $display("FAIL rst_async: req=%b valid=%b busy=%b err=%b data=%h",
               req, valid, busy, err, dout);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_idle: busy=%b, want 0", busy);
    end
    for (int i = 0; i < NB; i++) blk[i] = 8'(8'hFF - i);
    xfer(1'b1, NB, 2, -1, 1'b0, lat);
    vectors++;
    if (valid !== 1'b1 ||
        dout !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0) begin
      miscompares++;
      $display("FAIL rst_fresh: valid=%b data=%h, want 1 fffe..f1f0",
               valid, dout);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_random();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
